dispatch_scoreboard: RTL

//  Parametrised in-order dispatch stage with a register-status table (RST) and a per-FU busy check.

---
 rtl/dispatch_scoreboard.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dispatch_scoreboard.sv
// In-order dispatch stage: register-status table tags each source with its producing FU,
// stalls on FU-busy / WAW / unresolved branch, and holds one instruction toward issue.
module dispatch_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_FU   = 5,
  parameter int NUM_WB   = 2,
  localparam int TAG_W   = $clog2(NUM_FU + 1),
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int FU_W    = $clog2(NUM_FU)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_W-1:0]        in_rd,
  input  logic [REG_W-1:0]        in_rs1,
  input  logic [REG_W-1:0]        in_rs2,
  input  logic                    in_wen,
  input  logic [FU_W-1:0]         in_fu,
  input  logic                    in_branch,
  input  logic [NUM_FU-1:0]       fu_busy,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*REG_W-1:0] wb_rd,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic                    branch_resolved,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FU_W-1:0]         out_fu,
  output logic [REG_W-1:0]        out_rd,
  output logic [TAG_W-1:0]        out_t1,
  output logic [TAG_W-1:0]        out_t2,
  output logic [31:0]             stall_cycles,
  output logic                    dbg_state,
  output logic [NUM_REGS*TAG_W-1:0] dbg_tags
);

  typedef enum logic [0:0] {RUN = 1'b0, BR_WAIT = 1'b1} state_e;

  state_e             state_q;
  logic [TAG_W-1:0]   tag_q [NUM_REGS];
  logic [TAG_W-1:0]   tag_d [NUM_REGS];
  logic               out_valid_q;
  logic [FU_W-1:0]    out_fu_q;
  logic [REG_W-1:0]   out_rd_q;
  logic [TAG_W-1:0]   out_t1_q, out_t2_q;
  logic [TAG_W-1:0]   t1_d, t2_d;
  logic [31:0]        stall_q;

  logic [2**FU_W-1:0] busy_pad;
  logic               slot_free, waw, fire;
  logic [TAG_W-1:0]   dispatch_tag;

  // Handshake: in_ready is independent of in_valid; a transfer happens on in_valid && in_ready.
  // Toward issue, the slot is consumed on out_valid && out_ready and is otherwise held stable.
  always_comb begin
    busy_pad = '1;
    busy_pad[NUM_FU-1:0] = fu_busy;
  end

  assign slot_free    = !out_valid_q || out_ready;
  assign waw          = in_wen && (in_rd != '0) && (tag_q[in_rd] != '0);
  assign in_ready     = (state_q == RUN) && slot_free && !busy_pad[in_fu] && !waw && !flush;
  assign fire         = in_valid && in_ready;
  assign dispatch_tag = TAG_W'(in_fu) + TAG_W'(1);

  // Source tags with same-cycle writeback bypass (a matching writeback means the value is ready).
  always_comb begin
    t1_d = (in_rs1 == '0) ? '0 : tag_q[in_rs1];
    t2_d = (in_rs2 == '0) ? '0 : tag_q[in_rs2];
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wb_rd[i*REG_W +: REG_W] == in_rs1 &&
          wb_tag[i*TAG_W +: TAG_W] == tag_q[in_rs1]) t1_d = '0;
      if (wb_valid[i] && wb_rd[i*REG_W +: REG_W] == in_rs2 &&
          wb_tag[i*TAG_W +: TAG_W] == tag_q[in_rs2]) t2_d = '0;
    end
  end

  // Stale writebacks (tag mismatch) are ignored; a new dispatch to the same rd overrides the clear.
  always_comb begin
    tag_d = tag_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && tag_q[wb_rd[i*REG_W +: REG_W]] == wb_tag[i*TAG_W +: TAG_W])
        tag_d[wb_rd[i*REG_W +: REG_W]] = '0;
    end
    if (fire && in_wen && in_rd != '0) tag_d[in_rd] = dispatch_tag;
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      tag_q[r] <= RST ? '0 : tag_d[r];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_fu_q    <= '0;
      out_rd_q    <= '0;
      out_t1_q    <= '0;
      out_t2_q    <= '0;
      stall_q     <= '0;
    end else begin
      if (in_valid && !in_ready && stall_q != '1) stall_q <= stall_q + 32'd1;

      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (fire) begin
        out_valid_q <= 1'b1;
        out_fu_q    <= in_fu;
        out_rd_q    <= in_rd;
        out_t1_q    <= t1_d;
        out_t2_q    <= t2_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        RUN:     if (fire && in_branch) state_q <= BR_WAIT;
        BR_WAIT: if (branch_resolved)   state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (flush) state_q <= RUN;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_fu       = out_fu_q;
  assign out_rd       = out_rd_q;
  assign out_t1       = out_t1_q;
  assign out_t2       = out_t2_q;
  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    assign dbg_tags[g*TAG_W +: TAG_W] = tag_q[g];
  end

endmodule
